// File: rtl/std_cache_pkg.sv
// rtl/std_cache_pkg.sv - std cache subsystem types and sizes shared by the data-cache SRAM arbiter.
package std_cache_pkg;

    localparam int unsigned DCACHE_SET_ASSOC   = 4;
    localparam int unsigned DCACHE_INDEX_WIDTH = 8;
    localparam int unsigned DCACHE_TAG_WIDTH   = 12;
    localparam int unsigned DCACHE_LINE_WIDTH  = 64;
    localparam int unsigned DCACHE_BE_WIDTH    = DCACHE_LINE_WIDTH / 8;

    typedef logic [DCACHE_LINE_WIDTH-1:0] cache_line_t;
    typedef logic [DCACHE_BE_WIDTH-1:0]   cl_be_t;

    localparam int unsigned SNOOP_PORT_IDX = 0;

    typedef struct packed {
        logic [DCACHE_SET_ASSOC-1:0]   req;
        logic [DCACHE_INDEX_WIDTH-1:0] addr;
        logic                          we;
        cl_be_t                        be;
        cache_line_t                   wdata;
    } arb_req_t;

endpackage

// File: rtl/snoop_sram_arbiter_rr_core_picker.sv
// rtl/snoop_sram_arbiter_rr_core_picker.sv - round-robin first-one search over core requesters 1..NR_PORTS.
module rr_core_picker #(
    parameter int unsigned NR_PORTS = 3,
    parameter int unsigned IDX_W    = $clog2(NR_PORTS + 1)
) (
    input  logic [NR_PORTS-1:0] core_req_i,
    input  logic [IDX_W-1:0]    rr_ptr_i,
    output logic [IDX_W-1:0]    idx_o,
    output logic                valid_o
);

    // Pass one scans from the pointer upward, pass two wraps back to core 1.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 1; k <= int'(NR_PORTS); k++) begin
            if (!valid_o && core_req_i[k-1] && (k >= int'(32'(rr_ptr_i)))) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(k);
            end
        end
        for (int k = 1; k <= int'(NR_PORTS); k++) begin
            if (!valid_o && core_req_i[k-1] && (k < int'(32'(rr_ptr_i)))) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/snoop_sram_arbiter.sv
// rtl/snoop_sram_arbiter.sv - snoop-priority data-cache SRAM arbiter with starvation guard, lock and response pipe.
// Optional perf outputs (conflict_cnt_o, starve_evt_o) under SNOOP_SRAM_ARB_PERF_EN.
module snoop_sram_arbiter
    import std_cache_pkg::*;
#(
    parameter int unsigned NR_PORTS         = 3,
    parameter int unsigned SNOOP_MAX_CONSEC = 4
) (
    input  logic                                              clk_i,
    input  logic                                              rst_ni,
    input  logic [NR_PORTS:0][DCACHE_SET_ASSOC-1:0]           req_i,
    input  logic [NR_PORTS:0][DCACHE_INDEX_WIDTH-1:0]         addr_i,
    input  logic [NR_PORTS:0][DCACHE_TAG_WIDTH-1:0]           tag_i,
    input  logic [NR_PORTS:0]                                 we_i,
    input  logic [NR_PORTS:0][DCACHE_BE_WIDTH-1:0]            be_i,
    input  logic [NR_PORTS:0][DCACHE_LINE_WIDTH-1:0]          wdata_i,
    output logic [NR_PORTS:0]                                 gnt_o,
    output logic [NR_PORTS:0]                                 rvalid_o,
    output logic [DCACHE_SET_ASSOC-1:0]                       req_o,
    output logic [DCACHE_INDEX_WIDTH-1:0]                     addr_o,
    output logic [DCACHE_TAG_WIDTH-1:0]                       tag_o,
    output logic                                              we_o,
    output logic [DCACHE_BE_WIDTH-1:0]                        be_o,
    output logic [DCACHE_LINE_WIDTH-1:0]                      data_o,
    input  logic                                              gnt_i
`ifdef SNOOP_SRAM_ARB_PERF_EN
    ,
    output logic [31:0]                                       conflict_cnt_o,
    output logic                                              starve_evt_o
`endif
);

    localparam int unsigned N     = NR_PORTS + 1;
    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned CNT_W = $clog2(SNOOP_MAX_CONSEC + 1);
    localparam logic [IDX_W-1:0] SNOOP_IDX = IDX_W'(SNOOP_PORT_IDX);

    logic                lock_valid_q, lock_valid_d;
    logic [IDX_W-1:0]    lock_q, lock_d;
    logic                owner_valid_q, owner_valid_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;

    arb_req_t [NR_PORTS:0] port_req;
    logic [NR_PORTS-1:0]   core_req;
    logic                  snoop_req;
    logic                  any_core;
    logic                  force_core;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_valid;
    logic                  active;
    logic                  grant;

    always_comb begin
        for (int k = 0; k <= int'(NR_PORTS); k++) begin
            port_req[k].req   = req_i[k];
            port_req[k].addr  = addr_i[k];
            port_req[k].we    = we_i[k];
            port_req[k].be    = be_i[k];
            port_req[k].wdata = wdata_i[k];
        end
        for (int k = 1; k <= int'(NR_PORTS); k++) begin
            core_req[k-1] = |req_i[k];
        end
    end

    assign snoop_req  = |req_i[SNOOP_PORT_IDX];
    assign any_core   = |core_req;
    assign force_core = (starve_cnt_q == CNT_W'(SNOOP_MAX_CONSEC)) && any_core;

    rr_core_picker #(
        .NR_PORTS (NR_PORTS),
        .IDX_W    (IDX_W)
    ) u_picker (
        .core_req_i (core_req),
        .rr_ptr_i   (rr_ptr_q),
        .idx_o      (pick_idx),
        .valid_o    (pick_valid)
    );

    always_comb begin
        sel_idx   = '0;
        sel_valid = 1'b0;
        if (lock_valid_q) begin
            sel_idx   = lock_q;
            sel_valid = 1'b1;
        end else if (snoop_req && !force_core) begin
            sel_idx   = SNOOP_IDX;
            sel_valid = 1'b1;
        end else if (pick_valid) begin
            sel_idx   = pick_idx;
            sel_valid = 1'b1;
        end
    end

    // A locked requester that dropped its request yields nothing this cycle.
    assign active = sel_valid && (|req_i[sel_idx]);
    assign grant  = active && gnt_i;

    always_comb begin
        req_o    = '0;
        addr_o   = '0;
        we_o     = 1'b0;
        be_o     = '0;
        data_o   = '0;
        gnt_o    = '0;
        rvalid_o = '0;
        tag_o    = '0;
        if (active) begin
            req_o  = port_req[sel_idx].req;
            addr_o = port_req[sel_idx].addr;
            we_o   = port_req[sel_idx].we;
            be_o   = port_req[sel_idx].be;
            data_o = port_req[sel_idx].wdata;
        end
        if (grant) begin
            gnt_o[sel_idx] = 1'b1;
        end
        if (owner_valid_q) begin
            rvalid_o[owner_q] = 1'b1;
            tag_o             = tag_i[owner_q];
        end
    end

    always_comb begin
        lock_valid_d  = active && !gnt_i;
        lock_d        = lock_valid_d ? sel_idx : lock_q;
        owner_valid_d = grant;
        owner_d       = grant ? sel_idx : owner_q;
        rr_ptr_d      = rr_ptr_q;
        starve_cnt_d  = starve_cnt_q;
        if (grant && (sel_idx != SNOOP_IDX)) begin
            rr_ptr_d = (sel_idx == IDX_W'(NR_PORTS)) ? IDX_W'(1) : sel_idx + IDX_W'(1);
        end
        if (!any_core) begin
            starve_cnt_d = '0;
        end else if (grant) begin
            if (sel_idx == SNOOP_IDX) begin
                if (starve_cnt_q != CNT_W'(SNOOP_MAX_CONSEC)) begin
                    starve_cnt_d = starve_cnt_q + CNT_W'(1);
                end
            end else begin
                starve_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lock_valid_q  <= 1'b0;
            lock_q        <= '0;
            owner_valid_q <= 1'b0;
            owner_q       <= '0;
            rr_ptr_q      <= IDX_W'(1);
            starve_cnt_q  <= '0;
        end else begin
            lock_valid_q  <= lock_valid_d;
            lock_q        <= lock_d;
            owner_valid_q <= owner_valid_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            starve_cnt_q  <= starve_cnt_d;
        end
    end

`ifdef SNOOP_SRAM_ARB_PERF_EN
    logic [31:0]   conflict_cnt_q, conflict_cnt_d;
    logic          lock_forced_q, lock_forced_d;
    logic [N-1:0]  port_act;
    logic          forced_sel;

    assign port_act   = {core_req, snoop_req};
    assign forced_sel = !lock_valid_q && snoop_req && force_core;

    // A forced pick that had to wait under lock still counts once, when granted.
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (($countones(port_act) > 1) && !lock_valid_q) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
        lock_forced_d = lock_valid_d && (lock_valid_q ? lock_forced_q : forced_sel);
        starve_evt_o  = grant && (lock_valid_q ? lock_forced_q : forced_sel);
    end

    assign conflict_cnt_o = conflict_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            conflict_cnt_q <= '0;
            lock_forced_q  <= 1'b0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
            lock_forced_q  <= lock_forced_d;
        end
    end
`endif

endmodule

// File: tb/tb_snoop_sram_arbiter.sv
// tb/tb_snoop_sram_arbiter.sv - self-checking bench for snoop_sram_arbiter: vector table, corner sequences, random vs model.
module tb_snoop_sram_arbiter;
    import std_cache_pkg::*;

    localparam int NP   = 3;
    localparam int N    = NP + 1;
    localparam int MAXC = 4;

    logic                                      clk_i;
    logic                                      rst_ni;
    logic [NP:0][DCACHE_SET_ASSOC-1:0]         req_i;
    logic [NP:0][DCACHE_INDEX_WIDTH-1:0]       addr_i;
    logic [NP:0][DCACHE_TAG_WIDTH-1:0]         tag_i;
    logic [NP:0]                               we_i;
    logic [NP:0][DCACHE_BE_WIDTH-1:0]          be_i;
    logic [NP:0][DCACHE_LINE_WIDTH-1:0]        wdata_i;
    logic [NP:0]                               gnt_o;
    logic [NP:0]                               rvalid_o;
    logic [DCACHE_SET_ASSOC-1:0]               req_o;
    logic [DCACHE_INDEX_WIDTH-1:0]             addr_o;
    logic [DCACHE_TAG_WIDTH-1:0]               tag_o;
    logic                                      we_o;
    logic [DCACHE_BE_WIDTH-1:0]                be_o;
    logic [DCACHE_LINE_WIDTH-1:0]              data_o;
    logic                                      gnt_i;
`ifdef SNOOP_SRAM_ARB_PERF_EN
    logic [31:0]                               conflict_cnt_o;
    logic                                      starve_evt_o;
`endif

    snoop_sram_arbiter #(
        .NR_PORTS         (NP),
        .SNOOP_MAX_CONSEC (MAXC)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .addr_i   (addr_i),
        .tag_i    (tag_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .wdata_i  (wdata_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .req_o    (req_o),
        .addr_o   (addr_o),
        .tag_o    (tag_o),
        .we_o     (we_o),
        .be_o     (be_o),
        .data_o   (data_o),
        .gnt_i    (gnt_i)
`ifdef SNOOP_SRAM_ARB_PERF_EN
        ,
        .conflict_cnt_o (conflict_cnt_o),
        .starve_evt_o   (starve_evt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input logic [3:0] mask, input logic g);
        for (int k = 0; k < N; k++) begin
            req_i[k]   = mask[k] ? DCACHE_SET_ASSOC'(1 << k) : '0;
            addr_i[k]  = DCACHE_INDEX_WIDTH'(8'h10 + k);
            tag_i[k]   = DCACHE_TAG_WIDTH'(12'h100 + k);
            we_i[k]    = k[0];
            be_i[k]    = DCACHE_BE_WIDTH'(1 << k);
            wdata_i[k] = DCACHE_LINE_WIDTH'(64'ha0 + k);
        end
        gnt_i = g;
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic        gnt;
        logic [3:0]  exp_gnt;
        logic [3:0]  exp_rv;
        logic [7:0]  exp_addr;
        logic [11:0] exp_tag;
    } vec_t;

    vec_t tbl[25];

    // Behavioural reference state: -1 means none.
    int m_lock, m_owner, m_rr, m_cnt;

    initial begin
        logic [3:0] act;
        logic       any_core;
        int         sel;
        logic [3:0] e_gnt, e_rv;
        logic [DCACHE_SET_ASSOC-1:0]   e_req;
        logic [DCACHE_INDEX_WIDTH-1:0] e_addr;
        logic                          e_we;
        logic [DCACHE_BE_WIDTH-1:0]    e_be;
        logic [DCACHE_LINE_WIDTH-1:0]  e_data;
        logic [DCACHE_TAG_WIDTH-1:0]   e_tag;
        int evt_cnt;

        n_checks = 0;
        n_fail   = 0;
        evt_cnt  = 0;

        tbl[0]  = '{4'b1110, 1'b1, 4'b0010, 4'b0000, 8'h11, 12'h000};
        tbl[1]  = '{4'b1110, 1'b1, 4'b0100, 4'b0010, 8'h12, 12'h101};
        tbl[2]  = '{4'b1110, 1'b1, 4'b1000, 4'b0100, 8'h13, 12'h102};
        tbl[3]  = '{4'b1110, 1'b1, 4'b0010, 4'b1000, 8'h11, 12'h103};
        tbl[4]  = '{4'b1110, 1'b1, 4'b0100, 4'b0010, 8'h12, 12'h101};
        tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 4'b0100, 8'h00, 12'h102};
        tbl[6]  = '{4'b0010, 1'b1, 4'b0010, 4'b0000, 8'h11, 12'h000};
        tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 4'b0010, 8'h00, 12'h101};
        tbl[8]  = '{4'b0101, 1'b1, 4'b0001, 4'b0000, 8'h10, 12'h000};
        tbl[9]  = '{4'b0101, 1'b1, 4'b0001, 4'b0001, 8'h10, 12'h100};
        tbl[10] = '{4'b0101, 1'b1, 4'b0001, 4'b0001, 8'h10, 12'h100};
        tbl[11] = '{4'b0101, 1'b1, 4'b0001, 4'b0001, 8'h10, 12'h100};
        tbl[12] = '{4'b0101, 1'b1, 4'b0100, 4'b0001, 8'h12, 12'h100};
        tbl[13] = '{4'b0101, 1'b1, 4'b0001, 4'b0100, 8'h10, 12'h102};
        tbl[14] = '{4'b0000, 1'b1, 4'b0000, 4'b0001, 8'h00, 12'h100};
        tbl[15] = '{4'b1000, 1'b0, 4'b0000, 4'b0000, 8'h13, 12'h000};
        tbl[16] = '{4'b1001, 1'b0, 4'b0000, 4'b0000, 8'h13, 12'h000};
        tbl[17] = '{4'b1001, 1'b0, 4'b0000, 4'b0000, 8'h13, 12'h000};
        tbl[18] = '{4'b1001, 1'b1, 4'b1000, 4'b0000, 8'h13, 12'h000};
        tbl[19] = '{4'b0001, 1'b1, 4'b0001, 4'b1000, 8'h10, 12'h103};
        tbl[20] = '{4'b0000, 1'b0, 4'b0000, 4'b0001, 8'h00, 12'h100};
        tbl[21] = '{4'b0100, 1'b0, 4'b0000, 4'b0000, 8'h12, 12'h000};
        tbl[22] = '{4'b0001, 1'b1, 4'b0000, 4'b0000, 8'h00, 12'h000};
        tbl[23] = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 8'h10, 12'h000};
        tbl[24] = '{4'b0000, 1'b1, 4'b0000, 4'b0001, 8'h00, 12'h100};

        rst_ni = 1'b0;
        set_inputs(4'b0000, 1'b0);
        @(negedge clk_i);
        #1;
        check("reset_outputs", {gnt_o, rvalid_o, req_o, addr_o, tag_o, we_o, be_o, data_o}, '0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 25; i++) begin
            if (i != 0) @(negedge clk_i);
            set_inputs(tbl[i].mask, tbl[i].gnt);
            #1;
            check($sformatf("vec%0d_gnt", i), 128'(gnt_o), 128'(tbl[i].exp_gnt));
            check($sformatf("vec%0d_rvalid", i), 128'(rvalid_o), 128'(tbl[i].exp_rv));
            check($sformatf("vec%0d_addr", i), 128'(addr_o), 128'(tbl[i].exp_addr));
            check($sformatf("vec%0d_tag", i), 128'(tag_o), 128'(tbl[i].exp_tag));
        end

        // Reset while a lock is being taken and an rvalid is in flight.
        @(negedge clk_i);
        set_inputs(4'b0010, 1'b1);
        #1;
        check("mr_pre_gnt", 128'(gnt_o), 128'(4'b0010));
        @(negedge clk_i);
        rst_ni = 1'b0;
        set_inputs(4'b1000, 1'b0);
        #1;
        check("mr_pending_rvalid", 128'(rvalid_o), 128'(4'b0010));
        @(negedge clk_i);
        rst_ni = 1'b1;
        set_inputs(4'b0000, 1'b0);
        #1;
        check("mr_outputs_zero", {gnt_o, rvalid_o, req_o, addr_o, tag_o, we_o, be_o, data_o}, '0);
        @(negedge clk_i);
        set_inputs(4'b1110, 1'b1);
        #1;
        check("mr_rr_restart", 128'(gnt_o), 128'(4'b0010));
        @(negedge clk_i);
        set_inputs(4'b0101, 1'b1);
        #1;
        check("mr_snoop_first", 128'(gnt_o), 128'(4'b0001));

        // Randomized run against the reference model.
        @(negedge clk_i);
        rst_ni = 1'b0;
        set_inputs(4'b0000, 1'b0);
        @(negedge clk_i);
        rst_ni  = 1'b1;
        m_lock  = -1;
        m_owner = -1;
        m_rr    = 1;
        m_cnt   = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c != 0) @(negedge clk_i);
            for (int k = 0; k < N; k++) begin
                req_i[k]   = ($urandom_range(0, 1) == 1) ? DCACHE_SET_ASSOC'($urandom_range(1, 15)) : '0;
                addr_i[k]  = DCACHE_INDEX_WIDTH'($urandom);
                tag_i[k]   = DCACHE_TAG_WIDTH'($urandom);
                we_i[k]    = 1'($urandom);
                be_i[k]    = DCACHE_BE_WIDTH'($urandom);
                wdata_i[k] = {32'($urandom), 32'($urandom)};
            end
            if (m_lock >= 0 && $urandom_range(0, 9) != 0 && req_i[m_lock] == '0) begin
                req_i[m_lock] = DCACHE_SET_ASSOC'(1);
            end
            gnt_i = ($urandom_range(0, 9) < 7);
            #1;

            for (int k = 0; k < N; k++) act[k] = (req_i[k] != '0);
            any_core = |act[3:1];
            sel = -1;
            if (m_lock >= 0) begin
                if (act[m_lock]) sel = m_lock;
            end else if (act[0] && !(m_cnt == MAXC && any_core)) begin
                sel = 0;
            end else begin
                for (int off = 0; off < NP; off++) begin
                    int k;
                    k = ((m_rr - 1 + off) % NP) + 1;
                    if (sel < 0 && act[k]) sel = k;
                end
            end
            e_gnt  = (sel >= 0 && gnt_i) ? 4'(1 << sel) : 4'b0000;
            e_rv   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
            e_tag  = (m_owner >= 0) ? tag_i[m_owner] : '0;
            e_req  = (sel >= 0) ? req_i[sel] : '0;
            e_addr = (sel >= 0) ? addr_i[sel] : '0;
            e_we   = (sel >= 0) ? we_i[sel] : 1'b0;
            e_be   = (sel >= 0) ? be_i[sel] : '0;
            e_data = (sel >= 0) ? wdata_i[sel] : '0;

            check($sformatf("rand%0d_gnt", c), 128'(gnt_o), 128'(e_gnt));
            check($sformatf("rand%0d_rvalid", c), 128'(rvalid_o), 128'(e_rv));
            check($sformatf("rand%0d_tag", c), 128'(tag_o), 128'(e_tag));
            check($sformatf("rand%0d_sram", c), {req_o, addr_o, we_o, be_o, data_o},
                  {e_req, e_addr, e_we, e_be, e_data});

            m_lock = (sel >= 0 && !gnt_i) ? sel : -1;
            if (sel > 0 && gnt_i) m_rr = (sel % NP) + 1;
            if (!any_core) m_cnt = 0;
            else if (sel >= 0 && gnt_i) m_cnt = (sel == 0) ? ((m_cnt < MAXC) ? m_cnt + 1 : MAXC) : 0;
            m_owner = (sel >= 0 && gnt_i) ? sel : -1;
        end

`ifdef SNOOP_SRAM_ARB_PERF_EN
        @(negedge clk_i);
        rst_ni = 1'b0;
        set_inputs(4'b0000, 1'b0);
        #1;
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("perf_reset_conflict", 128'(conflict_cnt_o), 128'(0));
        for (int c = 0; c < 10; c++) begin
            if (c != 0) @(negedge clk_i);
            set_inputs(4'b0011, 1'b1);
            #1;
            if (starve_evt_o) evt_cnt++;
        end
        @(negedge clk_i);
        set_inputs(4'b0000, 1'b0);
        #1;
        check("perf_conflict_cnt", 128'(conflict_cnt_o), 128'(10));
        check("perf_starve_evts", 128'(evt_cnt), 128'(2));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snoop_sram_arbiter.md
Name: snoop_sram_arbiter

Overview:
- Shares the single data-cache SRAM port between the snoop cache controller and NR_PORTS core-side cache controllers.
- The snoop controller has priority, but a starvation guard bounds how long it can lock out the cores.
- A lock register holds the selected requester stable until the SRAM grants it.
- A one-cycle response pipeline routes the delayed tag and read-valid back to the owner.
- Sits between the cache controllers and the tag/data SRAM wrapper in the std cache subsystem.

Parameters:
- NR_PORTS, 3: number of core-side requesters. Requester index 0 is snoop; indices 1..NR_PORTS are cores; N = NR_PORTS+1.
- SNOOP_MAX_CONSEC, 4: consecutive snoop grants allowed while a core is waiting before one core grant is forced (>=1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- req_i  in  N x DCACHE_SET_ASSOC  per-requester way request; nonzero means requesting
- addr_i  in  N x DCACHE_INDEX_WIDTH  per-requester index
- tag_i  in  N x DCACHE_TAG_WIDTH  per-requester tag, presented the cycle after its grant
- we_i  in  N  write enable
- be_i  in  N x cl_be_t  byte/flag enables
- wdata_i  in  N x cache_line_t  write data
- gnt_o  out  N  one-hot grant
- rvalid_o  out  N  one-hot; SRAM outputs (data/hit/dirty/shared) are valid for this requester
- req_o  out  DCACHE_SET_ASSOC  to SRAM
- addr_o  out  DCACHE_INDEX_WIDTH  to SRAM
- tag_o  out  DCACHE_TAG_WIDTH  to SRAM, one cycle after the address
- we_o  out  1  to SRAM
- be_o  out  cl_be_t  to SRAM
- data_o  out  cache_line_t  to SRAM
- gnt_i  in  1  SRAM grant

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - lock_valid_q=0, owner_valid_q=0, rr_ptr_q=1, starve_cnt_q=0.
  - Every output is 0 whenever no request is present, including during the reset cycle's combinational evaluation.
- Selection (combinational each cycle):
  - If lock_valid_q, sel = lock_q.
  - Else if req_i[0]!=0 and not (starve_cnt_q==SNOOP_MAX_CONSEC and any core requests), sel = 0.
  - Else sel = the first requesting core at or after rr_ptr_q, wrapping NR_PORTS back to 1.
  - Else there is no selection.
- SRAM drive:
  - req_o, addr_o, we_o, be_o and data_o are muxed from sel; all are 0 when there is no selection.
  - gnt_o[sel] = gnt_i AND selected; all other gnt_o bits are 0; at most one bit is ever high.
- Lock:
  - Selection with gnt_i=0 sets lock_valid_q=1 and lock_q=sel.
  - Lock is released on the grant cycle. The locked requester must keep req_i asserted (its protocol is hold-until-grant).
  - If the locked requester deasserts req_i anyway, the lock is dropped that cycle with no grant issued, and re-arbitration happens next cycle.
- Round-robin pointer:
  - On a granted core k, rr_ptr_q <= k+1, wrapping to 1.
  - The pointer is unchanged on snoop grants and on idle cycles.
- Starvation counter:
  - On a snoop grant with any core req_i nonzero: increment, saturating at SNOOP_MAX_CONSEC.
  - On a core grant, or on a cycle with no core request: clear to 0.
- Response pipeline:
  - On any grant, owner_valid_q<=1 and owner_q<=sel; otherwise owner_valid_q<=0.
  - tag_o = tag_i[owner_q] when owner_valid_q, else 0.
  - rvalid_o[owner_q] = owner_valid_q. Latency is exactly 1 cycle after gnt_o.
  - Back-to-back grants are allowed. The tag for grant n and the address for grant n+1 are presented in the same cycle.
- Simultaneous events:
  - A snoop request arriving while a core is locked does not preempt that core.
  - A forced core grant is taken only when the lock is not held.
- Mid-operation reset: lock, owner and counters are cleared; any in-flight rvalid is dropped.

Optional Feature:
- SNOOP_SRAM_ARB_PERF_EN
- Defined: adds outputs
  - conflict_cnt_o[31:0]: increments on cycles where more than one requester is active and none is locked; wraps.
  - starve_evt_o (1-bit pulse): high on each forced core grant.
  - Both reset to 0.
- Undefined: these ports and their logic are absent, and behaviour is otherwise identical.

Decomposition:
- std_cache_pkg holds:
  - existing cache_line_t and cl_be_t;
  - new constant SNOOP_PORT_IDX=0;
  - typedef arb_req_t bundling {req, addr, we, be, wdata}.
- One sub-module, rr_core_picker: combinational round-robin first-one search over core requests, given rr_ptr; returns index and valid. The remaining logic stays in the top module.

Test Plan:
- Single core 1 request, gnt_i=1: gnt_o=0b0010 in the same cycle; rvalid_o=0b0010 and tag_o=tag_i[1] in the next cycle; rr_ptr becomes 2.
- Snoop and core 2 request together, SNOOP_MAX_CONSEC=4, gnt_i=1 continuously: snoop granted 4 cycles, core 2 granted in cycle 5, snoop granted again in cycle 6.
- Core 3 selected with gnt_i=0 for 3 cycles, snoop arrives in cycle 2: addr_o holds addr_i[3] throughout; first grant goes to core 3 when gnt_i=1; snoop is granted the next cycle.
- Cores 1, 2 and 3 all requesting continuously: grant order 1,2,3,1,2 with rvalid_o following each grant by one cycle.
- rst_ni=0 asserted while a lock is held and rvalid is pending: the next cycle has all outputs 0, rr_ptr=1 and starve_cnt=0.
- With SNOOP_SRAM_ARB_PERF_EN defined, 10 cycles of two-way contention: conflict_cnt_o=10, and starve_evt_o pulses once per forced core grant.
